// File: rtl/line_cache_reader.sv
// line_cache_reader: reads one line of WIDTH pixels from a line_cache read port
// and streams it downstream over valid/ready through a 2-entry skid FIFO. Rev 1.0
`default_nettype none

module line_cache_reader #(
  parameter int WIDTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH - 1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] index;
  logic              at_last;
  logic              in_flight;
  logic              in_flight_last;
  logic [7:0]        buf_data [2];
  logic [1:0]        buf_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occupancy;
  logic              push;
  logic              pop;
  logic [2:0]        pending;
  logic              issue_ok;
  logic              final_xfer;
  logic              drain_empty;

  assign at_last  = (index == LAST_ADDR);
  assign push     = in_flight;
  assign pop      = out_valid & out_ready;

  // Slots committed after this cycle: buffered + returning - leaving.
  assign pending  = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, pop};
  assign issue_ok = (pending < 3'd2);

  assign final_xfer  = pop & out_last;
  assign drain_empty = !in_flight && (occupancy == {1'b0, pop});

  assign out_valid = (occupancy != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_last  = out_valid & buf_last[rd_ptr];
  assign rd_addr   = index;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_READ;
      S_READ:  if (rd_en && at_last) state_next = S_DRAIN;
      S_DRAIN: if (drain_empty && final_xfer) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state)
      S_IDLE:  busy  = 1'b0;
      S_READ:  rd_en = issue_ok;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  // The index saturates at the last address so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= '0;
    end else if (state == S_IDLE && start) begin
      index <= '0;
    end else if (rd_en && !at_last) begin
      index <= index + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= rd_en;
      in_flight_last <= rd_en & at_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_data[0] <= 8'h00;
      buf_data[1] <= 8'h00;
      buf_last    <= 2'b00;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occupancy   <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= rd_data;
        buf_last[wr_ptr] <= in_flight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_cache_reader.sv
// tb_line_cache_reader: table-driven line scenarios with an expected-pixel queue.
`default_nettype none

module tb_line_cache_reader;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'h00;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  line_cache_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read cache model preloaded with 10..17.
  logic [7:0] cache [WIDTH];
  always @(posedge clk) if (rd_en) rd_data <= cache[rd_addr];

  typedef struct {
    string name;
    int    mode;
    bit    restart;
    int    exp_rd;
    int    exp_early;
    int    exp_first_valid;
    int    exp_last;
    int    exp_done;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  vec_t vecs[5];

  int errors = 0;
  int checks = 0;

  int rd_cnt, early, first_rd, first_rd_abs, fv, last_rel, done_rel, done_abs, done_cnt, pix;
  bit prev_stall;
  logic [7:0] prev_data;
  logic prev_last;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_vector();
    return int'({rd_en, rd_addr, out_valid, out_data, out_last, busy, done});
  endfunction

  function automatic logic ready_for(input int mode, input int rel);
    case (mode)
      0:       return 1'b1;
      1:       return (rel >= 10);
      2:       return (rel % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic sample(input int rel);
    exp_t e;
    if (rd_en) begin
      rd_cnt++;
      if (rel <= 9) early++;
      if (first_rd < 0) begin
        first_rd     = rel;
        first_rd_abs = cyc;
      end
    end
    check_eq("occupancy_le2", int'(dut.occupancy <= 2'd2), 1);
    if (prev_stall) begin
      check_eq("hold_valid", int'(out_valid), 1);
      check_eq("hold_data", int'(out_data), int'(prev_data));
      check_eq("hold_last", int'(out_last), int'(prev_last));
    end
    if (out_valid && fv < 0) fv = rel;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_pixel: got %0d expected none", out_data);
      end else begin
        e = q.pop_front();
        check_eq("pix_data", int'(out_data), int'(e.d));
        check_eq("pix_last", int'(out_last), int'(e.l));
      end
      pix++;
      if (out_last) last_rel = rel;
    end
    if (done) begin
      done_cnt++;
      if (done_rel < 0) begin
        done_rel = rel;
        done_abs = cyc;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  endtask

  // Entered and left #1 after a rising edge; start is raised in relative cycle 0.
  task automatic run_line(input vec_t v, input int abort_pix, output bit aborted);
    int rel;
    exp_t e;
    rd_cnt = 0; early = 0; first_rd = -1; first_rd_abs = -1; fv = -1;
    last_rel = -1; done_rel = -1; done_abs = -1; done_cnt = 0; pix = 0;
    prev_stall = 1'b0;
    q.delete();
    for (int i = 0; i < WIDTH; i++) begin
      e.d = 8'(10 + i);
      e.l = (i == WIDTH - 1);
      q.push_back(e);
    end
    aborted   = 1'b0;
    rel       = 0;
    start     = 1'b1;
    out_ready = ready_for(v.mode, 0);
    for (int it = 0; it < 120; it++) begin
      @(negedge clk);
      sample(rel);
      if (abort_pix >= 0 && pix == abort_pix) begin
        aborted = 1'b1;
        start   = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      rel++;
      start     = v.restart && (rel == 2 || rel == 5);
      out_ready = ready_for(v.mode, rel);
      if (done_rel >= 0 && rel == done_rel + 1) break;
    end
    start = 1'b0;
    check_eq({v.name, "_finished"}, int'(done_rel >= 0 && rel == done_rel + 1), 1);
    check_eq({v.name, "_busy_fall"}, int'(busy), 0);
    check_eq({v.name, "_pixels"}, pix, WIDTH);
    check_eq({v.name, "_queue_left"}, q.size(), 0);
    check_eq({v.name, "_done_pulses"}, done_cnt, 1);
    check_eq({v.name, "_rd_count"}, rd_cnt, v.exp_rd);
    check_eq({v.name, "_first_rd"}, first_rd, 1);
    check_eq({v.name, "_first_valid"}, fv, v.exp_first_valid);
    if (v.exp_early >= 0) check_eq({v.name, "_early_rd"}, early, v.exp_early);
    if (v.exp_last >= 0)  check_eq({v.name, "_last_cycle"}, last_rel, v.exp_last);
    if (v.exp_done >= 0)  check_eq({v.name, "_done_cycle"}, done_rel, v.exp_done);
  endtask

  initial begin
    bit ab;
    int prev_done_abs;

    for (int i = 0; i < WIDTH; i++) cache[i] = 8'(10 + i);
    void'($urandom(32'd7));

    vecs[0] = '{"ready_hi", 0, 1'b0, 8,  8, 3, 10, 11};
    vecs[1] = '{"stall10",  1, 1'b0, 8,  2, 3, 17, 18};
    vecs[2] = '{"alt",      2, 1'b0, 8, -1, 3, -1, -1};
    vecs[3] = '{"rand",     3, 1'b0, 8, -1, 3, -1, -1};
    vecs[4] = '{"restart",  0, 1'b1, 8,  8, 3, 10, 11};

    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("reset_outputs", out_vector(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_outputs", out_vector(), 0);

    for (int i = 0; i < 5; i++) run_line(vecs[i], -1, ab);

    // Back-to-back: second start lands in the cycle right after done.
    run_line(vecs[0], -1, ab);
    prev_done_abs = done_abs;
    run_line(vecs[0], -1, ab);
    check_eq("b2b_first_rd_gap", first_rd_abs - prev_done_abs, 2);

    // Asynchronous reset mid-cycle once pixel 3 has transferred.
    run_line(vecs[0], 4, ab);
    check_eq("abort_reached", int'(ab), 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("abort_outputs", out_vector(), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_rd_after_reset", int'(rd_en), 0);
      check_eq("idle_after_reset", int'(busy | out_valid), 0);
    end
    @(posedge clk);
    #1;
    run_line(vecs[0], -1, ab);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_cache_reader.md
Name: line_cache_reader

Overview:
- Read-side companion to the line-cache fill logic.
- Once a line of WIDTH 8-bit pixels has been written into a line_cache instance, this block sequentially reads addresses 0..WIDTH-1 from the cache's synchronous read port.
- It streams the pixels downstream over a valid/ready interface and marks the last pixel of the line.
- A 2-entry output buffer absorbs the cache's 1-cycle read latency, so backpressure never drops or duplicates a pixel.

Parameters:
- WIDTH, 640, pixels per line; number of reads per line.
- ADDR_W, 10, read-address width; must satisfy 2^ADDR_W >= WIDTH.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request to read one line; sampled only in IDLE.
- rd_en  output  1  read strobe to line_cache.
- rd_addr  output  ADDR_W  read address to line_cache.
- rd_data  input  8  cache read data; valid the cycle after rd_en.
- out_data  output  8  pixel to downstream.
- out_valid  output  1  out_data holds a pixel.
- out_ready  input  1  downstream accepts when high together with out_valid.
- out_last  output  1  high with out_valid on pixel index WIDTH-1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last pixel transfers.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Buffer is emptied, in-flight counter cleared, state=IDLE.
- Reset asserted mid-line aborts immediately. Data returning from the cache afterwards is ignored.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ when start=1. The read index is loaded with 0.
  - READ: issues reads. After the read of address WIDTH-1 is issued -> DRAIN.
  - DRAIN: no reads. When the in-flight count is 0, the buffer is empty, and the final transfer has occurred -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start asserted outside IDLE is ignored.
- Read issue:
  - In READ, rd_en=1 in a cycle iff (occupancy + in_flight - pop) < 2, where pop = out_valid & out_ready.
  - rd_addr is the current index. The index increments by 1 on each issued read. It never exceeds WIDTH-1 and never wraps.
  - rd_en=0 in all other states.
- Capture:
  - in_flight is 1 in the cycle after an issued read.
  - That cycle's rd_data is written into the buffer tail at the clock edge, together with a last tag (address == WIDTH-1).
- Buffer:
  - 2-entry FIFO. out_data, out_valid and out_last present the head.
  - Simultaneous push and pop is allowed at any occupancy; occupancy is unchanged.
  - Overflow is impossible by the issue rule. The bench asserts occupancy <= 2.
- Latency:
  - start high in cycle 0 -> READ and first rd_en in cycle 1 -> pixel 0 out_valid in cycle 3.
  - With out_ready held at 1: one pixel per cycle. Pixel k is valid in cycle 3+k, out_last in cycle WIDTH+2, done in cycle WIDTH+3, busy falls in cycle WIDTH+4.
- Backpressure:
  - out_valid, out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - Reads stall once 2 pixels are buffered or in flight.
- Arithmetic: all index math is unsigned ADDR_W bits. The comparison to WIDTH-1 is exact.

Test Plan:
- WIDTH=8, cache preloaded with 10,11..17; start pulse, out_ready=1 -> out_data 10..17 in cycles 3..10, out_last only with 17, done in cycle 11, exactly 8 rd_en pulses.
- Same setup, out_ready=0 for cycles 0..9 then 1 -> rd_en only in cycles 1 and 2. out_data=10 held stable through cycle 9, then 10..17 transfer in order with none lost or duplicated.
- out_ready toggling 1,0,1,0 (random seed fixed) -> output sequence 10..17 exact; occupancy never > 2; out_last on 17 only.
- start re-pulsed in cycles 2 and 5 while busy -> ignored; exactly 8 pixels; single done pulse.
- reset asserted asynchronously mid-cycle after pixel 3 transfers -> all outputs 0 immediately, no further rd_en. A new start then yields 10..17 from address 0.
- Back-to-back lines: start in the cycle after done -> second line identical, first rd_en two cycles after done.
